// File: rtl/rcpu_seq_ctrl.sv
// rtl/rcpu_seq_ctrl.sv - multi-cycle fetch/decode/exec/writeback sequencer for the R-type datapath
module rcpu_seq_ctrl #(
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 16,
  parameter int HALT_ON_OF = 1
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             run,
  input  logic             step,
  input  logic [31:0]      inst_in,
  input  logic             alu_of,
  input  logic             alu_zf,
  output logic             imem_re,
  output logic             pc_inc,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [2:0]       alu_op,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             ill_inst,
  output logic             of_flag,
  output logic             zf_flag,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic             ill_q, ill_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       func_ok;
  logic [2:0] dec_op;
  logic       is_nop;
  logic       is_halt;
  logic       is_legal;
  logic       is_illegal;
  logic       is_addsub;
  logic       of_trap;
  logic       wb_write;
  logic       wait_done;

  // Instruction classification works off the latched IR only, so outputs stay Moore.
  always_comb begin
    func_ok = 1'b1;
    dec_op  = 3'b000;
    case (ir_q[5:0])
      6'b100100: dec_op = 3'b000;
      6'b100101: dec_op = 3'b001;
      6'b100000: dec_op = 3'b010;
      6'b100110: dec_op = 3'b011;
      6'b100111: dec_op = 3'b100;
      6'b000100: dec_op = 3'b101;
      6'b100010: dec_op = 3'b110;
      6'b101010: dec_op = 3'b111;
      default:   func_ok = 1'b0;
    endcase
    is_nop     = (ir_q == 32'd0);
    is_halt    = (ir_q[31:26] == 6'b111111);
    is_legal   = (ir_q[31:26] == 6'b000000) && func_ok;
    is_illegal = !is_nop && !is_halt && !is_legal;
    is_addsub  = is_legal && ((ir_q[5:0] == 6'b100000) || (ir_q[5:0] == 6'b100010));
    of_trap    = (HALT_ON_OF != 0) && is_addsub && of_q;
    wb_write   = is_legal && (ir_q[15:11] != 5'd0) && !of_trap;
  end

  assign wait_done = (state_q == S_WAIT) && (wcnt_q == WAIT_LAST);

  always_ff @(posedge clka) begin
    if (!rsta) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run || step) state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT:   if (wait_done) state_d = S_DECODE;
      S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        if (of_trap)  state_d = S_HALT;
        else if (run) state_d = S_FETCH;
        else          state_d = S_IDLE;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_re = (state_q == S_FETCH);
    pc_inc  = (state_q == S_WB);
    rf_we   = (state_q == S_WB) && wb_write;
    busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    halted  = (state_q == S_HALT);
    alu_op  = 3'b000;
    if (((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_WB)) && is_legal) begin
      alu_op = dec_op;
    end
  end

  always_comb begin
    ir_d   = ir_q;
    wcnt_d = (state_q == S_WAIT) ? wcnt_q + 3'd1 : 3'd0;
    ill_d  = ill_q;
    of_d   = of_q;
    zf_d   = zf_q;
    cnt_d  = cnt_q;
    if (wait_done) ir_d = inst_in;
    if ((state_q == S_DECODE) && is_illegal) ill_d = 1'b1;
    if (state_q == S_EXEC) begin
      of_d = alu_of;
      zf_d = alu_zf;
    end
    // Saturating retire count; every instruction that reaches WB retires.
    if ((state_q == S_WB) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      ir_q   <= 32'd0;
      wcnt_q <= 3'd0;
      ill_q  <= 1'b0;
      of_q   <= 1'b0;
      zf_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ir_q   <= ir_d;
      wcnt_q <= wcnt_d;
      ill_q  <= ill_d;
      of_q   <= of_d;
      zf_q   <= zf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign ill_inst = ill_q;
  assign of_flag  = of_q;
  assign zf_flag  = zf_q;
  assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_rcpu_seq_ctrl.sv
// tb/tb_rcpu_seq_ctrl.sv - directed plus randomized instruction-level checks of rcpu_seq_ctrl
module tb_rcpu_seq_ctrl;

  localparam int LAT = 1;
  localparam int D   = 2 + LAT;
  localparam int N   = 4 + LAT;

  logic        clka = 1'b0;
  logic        rsta;
  logic        run;
  logic        step;
  logic [31:0] inst_in;
  logic        alu_of;
  logic        alu_zf;
  logic        imem_re;
  logic        pc_inc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [2:0]  alu_op;
  logic        rf_we;
  logic        busy;
  logic        halted;
  logic        ill_inst;
  logic        of_flag;
  logic        zf_flag;
  logic [15:0] inst_cnt;

  always #5 clka = ~clka;

  rcpu_seq_ctrl #(.MEM_LAT(LAT), .CNT_W(16), .HALT_ON_OF(1)) dut (
    .clka(clka), .rsta(rsta), .run(run), .step(step), .inst_in(inst_in),
    .alu_of(alu_of), .alu_zf(alu_zf), .imem_re(imem_re), .pc_inc(pc_inc),
    .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .rf_we(rf_we), .busy(busy),
    .halted(halted), .ill_inst(ill_inst), .of_flag(of_flag), .zf_flag(zf_flag),
    .inst_cnt(inst_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [5:0] func_tbl [8] = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h27, 6'h04, 6'h22, 6'h2a};

  int          m_cnt;
  bit          m_ill;
  bit          m_of;
  bit          m_zf;
  bit          m_running;
  bit          m_halted;
  logic [31:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_check(input string tag);
    @(negedge clka);
    chk({tag, "_imem_re"}, 32'(imem_re), 32'd0);
    chk({tag, "_pc_inc"}, 32'(pc_inc), 32'd0);
    chk({tag, "_regs"}, 32'({rs, rt, rd}), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_ill"}, 32'(ill_inst), 32'd0);
    chk({tag, "_flags"}, 32'({of_flag, zf_flag}), 32'd0);
    chk({tag, "_cnt"}, 32'(inst_cnt), 32'd0);
    rsta      = 1'b1;
    m_cnt     = 0;
    m_ill     = 1'b0;
    m_of      = 1'b0;
    m_zf      = 1'b0;
    m_ir      = 32'd0;
    m_running = 1'b0;
    m_halted  = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] ins, input bit aof, input bit azf,
                          input bit trig_run, input bit cont, input int step_at, input int rst_at);
    bit nop, hlt, legal, illegal, trap, wbok;
    int idx;
    logic [2:0] eop;
    idx = -1;
    for (int i = 0; i < 8; i++) if (ins[5:0] == func_tbl[i]) idx = i;
    nop     = (ins == 32'd0);
    hlt     = (ins[31:26] == 6'h3f);
    legal   = (ins[31:26] == 6'd0) && (idx >= 0);
    illegal = !nop && !hlt && !legal;
    eop     = legal ? 3'(idx) : 3'd0;
    trap    = legal && ((idx == 2) || (idx == 6)) && aof;
    wbok    = legal && (ins[15:11] != 5'd0) && !trap;

    if (!m_running) begin
      @(negedge clka);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_imem_re", 32'(imem_re), 32'd0);
      if (trig_run) begin
        run = 1'b1;
      end else begin
        run  = 1'b0;
        step = 1'b1;
      end
    end
    inst_in = ins;
    alu_of  = aof;
    alu_zf  = azf;

    for (int k = 1; k <= N; k++) begin
      @(negedge clka);
      step = 1'b0;
      if (k == step_at) step = 1'b1;
      if (k == N) run = cont;
      chk("imem_re", 32'(imem_re), 32'(k == 1));
      chk("busy", 32'(busy), 32'(hlt ? (k <= D) : 1'b1));
      chk("halted", 32'(halted), 32'(hlt && (k > D)));
      chk("alu_op", 32'(alu_op), 32'((!hlt && k >= D) ? eop : 3'd0));
      chk("regs", 32'({rs, rt, rd}), 32'((k >= D) ? ins[25:11] : m_ir[25:11]));
      chk("ill_inst", 32'(ill_inst), 32'((k > D) ? (m_ill | illegal) : m_ill));
      chk("flags", 32'({of_flag, zf_flag}), 32'((!hlt && k == N) ? {aof, azf} : {m_of, m_zf}));
      chk("rf_we", 32'(rf_we), 32'((k == N) && wbok));
      chk("pc_inc", 32'(pc_inc), 32'((k == N) && !hlt));
      chk("inst_cnt", 32'(inst_cnt), 32'(m_cnt));
      if (k == rst_at) begin
        rsta = 1'b0;
        run  = 1'b0;
        step = 1'b0;
        reset_check("midop_rst");
        return;
      end
    end

    if (!hlt) m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
    m_ill = m_ill | illegal;
    if (!hlt) begin
      m_of = aof;
      m_zf = azf;
    end
    m_ir      = ins;
    m_halted  = hlt || trap;
    m_running = cont && !m_halted;

    if (m_halted) begin
      run = 1'b1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clka);
        step = 1'(j == 1);
        chk("hold_halted", 32'(halted), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_imem_re", 32'(imem_re), 32'd0);
        chk("hold_pc_inc", 32'(pc_inc), 32'd0);
        chk("hold_rf_we", 32'(rf_we), 32'd0);
        chk("hold_cnt", 32'(inst_cnt), 32'(m_cnt));
      end
      step = 1'b0;
    end
  endtask

  task automatic halt_reset();
    rsta = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    reset_check("halt_rst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    int sel;
    int sa;
    int ra;
    rsta = 1'b0; run = 1'b0; step = 1'b0; inst_in = 32'd0; alu_of = 1'b0; alu_zf = 1'b0;
    @(negedge clka);
    reset_check("por");

    // Free-run add, then a back-to-back add with no idle cycle between.
    do_instr(32'h0022_1820, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    do_instr(32'h0062_2020, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    // Single step with an ignored second pulse in cycle 2.
    do_instr(32'h0043_2825, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    // Illegal opcode, then a legal one (sticky flag).
    do_instr(32'h8C22_0004, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(32'h0022_182A, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(32'h0022_0020, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Overflow trap on sub.
    do_instr(32'h0022_1822, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    if (m_halted) halt_reset();
    do_instr(32'hFC00_0000, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    if (m_halted) halt_reset();
    // Reset in EXEC, and reset coinciding with WB after one retired instruction.
    do_instr(32'h0022_1820, 1'b0, 1'b1, 1'b0, 1'b0, 0, D + 1);
    do_instr(32'h0022_1824, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_instr(32'h0022_1826, 1'b1, 1'b1, 1'b1, 1'b0, 0, N);

    for (int n = 0; n < 80; n++) begin
      r   = $urandom();
      sel = $urandom_range(0, 11);
      if (sel <= 5) ins = {6'd0, r[25:6], func_tbl[$urandom_range(0, 7)]};
      else if (sel == 6) ins = 32'd0;
      else if (sel == 7) begin
        if (r[31:26] == 6'h3f) r[31:26] = 6'h01;
        ins = r;
      end
      else if (sel == 8) ins = {6'd0, r[25:0]};
      else if (sel == 9) ins = ($urandom_range(0, 2) == 0) ? {6'h3f, r[25:0]} : {6'd0, r[25:6], 6'h2a};
      else ins = {6'd0, r[25:6], r[0] ? 6'h20 : 6'h22};
      sa = $urandom_range(0, 3);
      if (sa < 2) sa = 0;
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(1, N) : 0;
      do_instr(ins, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sa, ra);
      if (m_halted) halt_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
